// File: rtl/n64_read_response_if.sv
// n64_read_response_if: start/line/result bundle between the N64 read
// receiver (slave) and the logic that starts reads and consumes words (master).
interface n64_read_response_if #(
    parameter int unsigned NUM_BITS = 32
);
    logic                begin_read;
    logic                data_in;
    logic [NUM_BITS-1:0] data_out;
    logic                data_valid;
    logic                busy;
    logic                timeout_err;

    modport master (
        output begin_read, data_in,
        input  data_out, data_valid, busy, timeout_err
    );

    modport slave (
        input  begin_read, data_in,
        output data_out, data_valid, busy, timeout_err
    );
endinterface

// File: rtl/n64_read_response.sv
// n64_read_response: decodes the controller's pulse-width-coded reply on the
// N64 data line (MSB first), sampling SAMPLE cycles after each falling edge.
// It delivers the word with a one-cycle valid strobe and aborts with
// timeout_err if the line stops toggling.
// Optional build macro N64_READ_STOP_CHECK_EN: require the controller stop bit
// (falling edge, then line high) before accepting the word.
module n64_read_response #(
    parameter int unsigned NUM_BITS = 32,
    parameter int unsigned SAMPLE   = 200,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    n64_read_response_if.slave    bus
);

    localparam int unsigned CNT_MAX = (TIMEOUT > SAMPLE) ? TIMEOUT : SAMPLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        SAMPLE_WAIT,
        WAIT_RISE,
        STOP,
        DONE
`ifdef N64_READ_STOP_CHECK_EN
        ,
        STOP_HIGH
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q;
    logic                s_q;
    logic                s_prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                timeout_err_q, timeout_err_d;

    logic fall;
    logic tmo;

    assign fall = s_prev_q & ~s_q;
    assign tmo  = (cnt_q == TIMEOUT_LAST);

    // Two-flop synchronizer for the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            s_q      <= 1'b1;
            s_prev_q <= 1'b1;
        end else begin
            sync1_q  <= bus.data_in;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
        end
    end

    // Frame state, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; in every wait state the awaited event wins over timeout expiry.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.begin_read) begin
                    state_d = WAIT_FALL;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            WAIT_FALL: begin
                if (fall) begin
                    state_d = SAMPLE_WAIT;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SAMPLE_WAIT: begin
                if (cnt_q == SAMPLE_LAST) begin
                    shift_d = {shift_q[NUM_BITS-2:0], s_q};
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = WAIT_RISE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_RISE: begin
                if (s_q) begin
                    state_d = WAIT_FALL;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef N64_READ_STOP_CHECK_EN
            STOP: begin
                if (fall) begin
                    state_d = STOP_HIGH;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP_HIGH: begin
                if (s_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`else
            STOP: begin
                if (s_q) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            DONE: begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_n64_read_response.sv
// tb_n64_read_response: scoreboard bench for n64_read_response with scaled
// timing (SAMPLE=20, TIMEOUT=100, bits 30/10 cycles low). Honours
// N64_READ_STOP_CHECK_EN for the stop-bit expectations.
module tb_n64_read_response;

    localparam int unsigned NB    = 32;
    localparam int unsigned SMP   = 20;
    localparam int unsigned TMO   = 100;
    localparam int unsigned LONG  = 30;
    localparam int unsigned SHORT = 10;
    localparam int          FRAME_BUDGET = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    n64_read_response_if #(.NUM_BITS(NB)) ifc ();

    n64_read_response #(
        .NUM_BITS (NB),
        .SAMPLE   (SMP),
        .TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] last_word = '0;
    int valid_cnt = 0;
    int terr_cnt  = 0;

    // Pulse counters for "exactly one" / "none" checks.
    always @(negedge clk) begin
        if (ifc.data_valid)  valid_cnt <= valid_cnt + 1;
        if (ifc.timeout_err) terr_cnt  <= terr_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_begin();
        ifc.begin_read = 1'b1;
        @(negedge clk);
        ifc.begin_read = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        ifc.data_in = 1'b0;
        repeat (b ? SHORT : LONG) @(negedge clk);
        ifc.data_in = 1'b1;
        repeat (b ? LONG : SHORT) @(negedge clk);
    endtask

    task automatic send_bits(input logic [NB-1:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) drive_bit(w[NB-1-i]);
    endtask

    task automatic send_stop();
        ifc.data_in = 1'b0;
        repeat (SHORT) @(negedge clk);
        ifc.data_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks++; if (ifc.data_out !== '0) $display("FAIL reset_data_out: got %h expected 0", ifc.data_out); else n_pass++;
        n_checks++; if (ifc.data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", ifc.data_valid); else n_pass++;
        n_checks++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ifc.busy); else n_pass++;
        n_checks++; if (ifc.timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", ifc.timeout_err); else n_pass++;
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_nominal();
        logic [NB-1:0] w = 32'hA5C3_0F81;
        logic [NB-1:0] e;
        bit got = 0;
        int v0 = valid_cnt;
        exp_q.push_back(w);
        pulse_begin();
        n_checks++; if (ifc.busy !== 1'b1) $display("FAIL nominal_busy_start: got %b expected 1", ifc.busy); else n_pass++;
        fork
            begin
                send_bits(w, 0, NB);
                send_stop();
            end
            begin
                for (int c = 0; c < FRAME_BUDGET && !got; c++) begin
                    @(negedge clk);
                    if (ifc.data_valid) begin
                        got = 1;
                        e = exp_q.pop_front();
                        n_checks++; if (ifc.data_out !== e) $display("FAIL nominal_data: got %h expected %h", ifc.data_out, e); else n_pass++;
                        last_word = e;
                        @(negedge clk);
                        n_checks++; if (ifc.busy !== 1'b0) $display("FAIL nominal_busy_end: got %b expected 0", ifc.busy); else n_pass++;
                        n_checks++; if (ifc.data_valid !== 1'b0) $display("FAIL nominal_valid_width: got %b expected 0", ifc.data_valid); else n_pass++;
                    end
                end
            end
        join
        n_checks++; if (got !== 1'b1) $display("FAIL nominal_seen: got %b expected 1 (no data_valid)", got); else n_pass++;
        if (!got) exp_q.delete();
        idle(10);
        n_checks++; if (valid_cnt - v0 !== 1) $display("FAIL nominal_valid_count: got %0d expected 1", valid_cnt - v0); else n_pass++;
    endtask

    task automatic test_no_response();
        int k = 0;
        bit seen = 0;
        int v0 = valid_cnt;
        pulse_begin();
        n_checks++; if (ifc.busy !== 1'b1) $display("FAIL noresp_busy: got %b expected 1", ifc.busy); else n_pass++;
        while (!seen && k < int'(TMO) + 50) begin
            @(negedge clk);
            k++;
            if (ifc.timeout_err) seen = 1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL noresp_seen: got %b expected 1 (no timeout_err)", seen); else n_pass++;
        n_checks++; if (k !== int'(TMO)) $display("FAIL noresp_latency: got %0d expected %0d", k, TMO); else n_pass++;
        n_checks++; if (ifc.busy !== 1'b0) $display("FAIL noresp_busy_end: got %b expected 0", ifc.busy); else n_pass++;
        n_checks++; if (ifc.data_out !== last_word) $display("FAIL noresp_data_kept: got %h expected %h", ifc.data_out, last_word); else n_pass++;
        idle(5);
        n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL noresp_no_valid: got %0d expected 0", valid_cnt - v0); else n_pass++;
    endtask

    task automatic test_truncated();
        int k = 0;
        bit seen = 0;
        int v0 = valid_cnt;
        int t0 = terr_cnt;
        pulse_begin();
        send_bits(32'h1234_ABCD, 0, 16);
        while (!seen && k < int'(TMO) + 50) begin
            @(negedge clk);
            k++;
            if (ifc.timeout_err) seen = 1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL trunc_timeout: got %b expected 1", seen); else n_pass++;
        n_checks++; if (ifc.data_out !== last_word) $display("FAIL trunc_data_kept: got %h expected %h", ifc.data_out, last_word); else n_pass++;
        idle(5);
        n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL trunc_no_valid: got %0d expected 0", valid_cnt - v0); else n_pass++;
        n_checks++; if (terr_cnt - t0 !== 1) $display("FAIL trunc_terr_count: got %0d expected 1", terr_cnt - t0); else n_pass++;
    endtask

    task automatic test_stop_omitted();
        logic [NB-1:0] w = 32'h5A5A_3C3C;
        logic [NB-1:0] e;
        bit got_v = 0;
        bit got_t = 0;
`ifndef N64_READ_STOP_CHECK_EN
        exp_q.push_back(w);
`endif
        pulse_begin();
        fork
            send_bits(w, 0, NB);
            begin
                for (int c = 0; c < FRAME_BUDGET && !got_v && !got_t; c++) begin
                    @(negedge clk);
                    if (ifc.data_valid) begin
                        got_v = 1;
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            n_checks++; if (ifc.data_out !== e) $display("FAIL nostop_data: got %h expected %h", ifc.data_out, e); else n_pass++;
                            last_word = e;
                        end
                    end
                    if (ifc.timeout_err) got_t = 1;
                end
            end
        join
`ifdef N64_READ_STOP_CHECK_EN
        n_checks++; if (got_t !== 1'b1) $display("FAIL nostop_timeout: got %b expected 1", got_t); else n_pass++;
        n_checks++; if (got_v !== 1'b0) $display("FAIL nostop_valid: got %b expected 0", got_v); else n_pass++;
`else
        n_checks++; if (got_v !== 1'b1) $display("FAIL nostop_valid: got %b expected 1", got_v); else n_pass++;
        n_checks++; if (got_t !== 1'b0) $display("FAIL nostop_timeout: got %b expected 0", got_t); else n_pass++;
`endif
        exp_q.delete();
        n_checks++; if (ifc.data_out !== last_word) $display("FAIL nostop_data_out: got %h expected %h", ifc.data_out, last_word); else n_pass++;
        idle(TMO + 20);
    endtask

    task automatic test_reset_mid_frame();
        logic [NB-1:0] w = 32'hFFFF_FFFF;
        logic [NB-1:0] e;
        bit got = 0;
        pulse_begin();
        send_bits(32'h0F0F_0F0F, 0, 10);
        rst = 1'b1;
        #1;
        n_checks++; if (ifc.data_out !== '0) $display("FAIL midrst_data_out: got %h expected 0", ifc.data_out); else n_pass++;
        n_checks++; if (ifc.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", ifc.busy); else n_pass++;
        n_checks++; if ({ifc.data_valid, ifc.timeout_err} !== 2'b00) $display("FAIL midrst_pulses: got %b expected 00", {ifc.data_valid, ifc.timeout_err}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        last_word = '0;
        idle(5);
        exp_q.push_back(w);
        pulse_begin();
        fork
            begin
                send_bits(w, 0, NB);
                send_stop();
            end
            begin
                for (int c = 0; c < FRAME_BUDGET && !got; c++) begin
                    @(negedge clk);
                    if (ifc.data_valid) begin
                        got = 1;
                        e = exp_q.pop_front();
                        n_checks++; if (ifc.data_out !== e) $display("FAIL midrst_next_frame: got %h expected %h", ifc.data_out, e); else n_pass++;
                        last_word = e;
                    end
                end
            end
        join
        n_checks++; if (got !== 1'b1) $display("FAIL midrst_seen: got %b expected 1", got); else n_pass++;
        if (!got) exp_q.delete();
        idle(10);
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] w1 = 32'hC3A5_0F1E;
        logic [NB-1:0] w2 = 32'h0000_0001;
        logic [NB-1:0] e;
        bit got1 = 0;
        bit got2 = 0;
        int v0 = valid_cnt;
        exp_q.push_back(w1);
        pulse_begin();
        fork
            begin
                send_bits(w1, 0, 5);
                pulse_begin();
                send_bits(w1, 5, NB - 5);
`ifdef N64_READ_STOP_CHECK_EN
                send_stop();
`endif
            end
            begin
                for (int c = 0; c < FRAME_BUDGET && !got1; c++) begin
                    @(negedge clk);
                    if (ifc.data_valid) begin
                        got1 = 1;
                        e = exp_q.pop_front();
                        n_checks++; if (ifc.data_out !== e) $display("FAIL b2b_first: got %h expected %h", ifc.data_out, e); else n_pass++;
                        @(negedge clk);
                        pulse_begin();
                    end
                end
            end
        join
        n_checks++; if (got1 !== 1'b1) $display("FAIL b2b_first_seen: got %b expected 1", got1); else n_pass++;
        exp_q.delete();
        exp_q.push_back(w2);
        fork
            begin
                send_bits(w2, 0, NB);
                send_stop();
            end
            begin
                for (int c = 0; c < FRAME_BUDGET && !got2; c++) begin
                    @(negedge clk);
                    if (ifc.data_valid) begin
                        got2 = 1;
                        e = exp_q.pop_front();
                        n_checks++; if (ifc.data_out !== e) $display("FAIL b2b_second: got %h expected %h", ifc.data_out, e); else n_pass++;
                    end
                end
            end
        join
        n_checks++; if (got2 !== 1'b1) $display("FAIL b2b_second_seen: got %b expected 1", got2); else n_pass++;
        exp_q.delete();
        idle(10);
        n_checks++; if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); else n_pass++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        ifc.begin_read = 1'b0;
        ifc.data_in    = 1'b1;
        rst            = 1'b1;
        test_reset();
        test_nominal();
        test_no_response();
        test_truncated();
        test_stop_omitted();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
